z80_bus_target: RTL
===================

Name: z80_bus_target

Overview:
- Memory/IO responder on the Z80 CPU bus; the target side of the CPU core's rd/wr/adr/data strobes.
- Decodes the address map and returns read data from program ROM, work RAM and input ports.
- Stalls the CPU with wait_n while an external ROM fetch (SDRAM loader path) completes.
- Generates the VBLANK interrupt request and latches CPU-written control registers.

Parameters:
- ROM_AW, 15, ROM byte-address width (ROM window 0x0000-0x7FFF).
- RAM_AW, 11, work-RAM address width (2 KiB at 0x8000, mirrored through 0x8FFF).
- ROM_TIMEOUT, 255, cycles waiting for rom_ack before forcing completion with data 0xFF.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_adr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_rd  in  1  memory read strobe, active-high, level for the whole access.
- cpu_wr  in  1  memory write strobe, active-high.
- cpu_din  out  8  read data to CPU.
- cpu_wait_n  out  1  active-low wait to CPU.
- cpu_intreq  out  1  interrupt request to CPU, active-high.
- vblank  in  1  video vertical blank, synchronous to clk.
- rom_req  out  1  external ROM fetch request, level.
- rom_adr  out  ROM_AW  ROM byte address.
- rom_ack  in  1  one-cycle pulse; rom_data is valid in the same cycle.
- rom_data  in  8  ROM byte.
- ram_adr  out  RAM_AW  work-RAM address.
- ram_we  out  1  work-RAM write enable.
- ram_wdata  out  8  work-RAM write data.
- ram_rdata  in  8  work-RAM data; synchronous, 1-cycle latency.
- in_p1, in_p2, in_dsw  in  8 each  input ports.
- flip  out  1  screen flip control bit.

Behaviour:
- Address map:
  - 0x0000-0x7FFF: ROM.
  - 0x8000-0x8FFF: RAM (mirror, using adr[RAM_AW-1:0]).
  - 0xA000 read: in_p1. 0xA001 read: in_p2. 0xA002 read: in_dsw.
  - 0xA000 write: irq_en = dout[0]. 0xA001 write: flip = dout[0]. 0xA002 write (any value): interrupt acknowledge.
  - Unmapped reads return 0xFF. Unmapped writes are ignored.
- Access start: the first cycle in which cpu_rd or cpu_wr is high while the FSM is in IDLE. If both are high, the access is treated as a write.
- FSM states: IDLE, ROM_FETCH, RAM_RD, HOLD.
  - IDLE + ROM read + cache hit (valid && tag == adr[ROM_AW-1:0]): cpu_din = cached byte in the same cycle; go to HOLD.
  - IDLE + ROM read + cache miss: cpu_wait_n = 0 combinationally in the start cycle; rom_req = 1 and rom_adr latched on the next edge; go to ROM_FETCH.
  - ROM_FETCH: on rom_ack, latch rom_data into cache and cpu_din, clear rom_req, release wait, go to HOLD.
  - ROM_FETCH timeout: after ROM_TIMEOUT cycles without rom_ack, return 0xFF, do not update cache, go to HOLD.
  - IDLE + RAM read: wait_n = 0 for exactly 1 cycle; ram_adr is driven; in RAM_RD, cpu_din = ram_rdata; go to HOLD.
  - IDLE + RAM write: ram_we = 1 for exactly 1 cycle with ram_adr/ram_wdata; go to HOLD.
  - IDLE + IO or unmapped access: served in the same cycle; go to HOLD.
  - HOLD: cpu_din is stable; return to IDLE when cpu_rd and cpu_wr are both 0.
- Each strobe produces at most one ram_we and one rom_req.
- cpu_wait_n is low only during ROM_FETCH, the RAM_RD entry cycle and the miss start cycle. It is high at all other times, including under reset.
- Interrupt:
  - A vblank rising edge (registered previous value) with irq_en = 1 sets cpu_intreq.
  - A write to 0xA002, or writing irq_en = 0, clears cpu_intreq.
  - If an edge and a clear occur in the same cycle, the clear wins.
- Strobe dropped mid-fetch: the FSM still waits for rom_ack (or timeout) before IDLE, so a late ack is never mistaken for the next fetch.
- Reset values:
  - cpu_din = 0xFF, cpu_wait_n = 1, cpu_intreq = 0, rom_req = 0, rom_adr = 0, ram_we = 0, ram_adr = 0, flip = 0.
  - irq_en = 0, cache invalid, FSM = IDLE, vblank edge register = 0.
  - Reset asserted mid-fetch aborts the fetch immediately; rom_req drops asynchronously.
- Width rules: ROM/RAM addresses are truncated slices of cpu_adr. The timeout counter is ceil(log2(ROM_TIMEOUT+1)) bits and saturates.

Decomposition:
- Package z80_bus_pkg:
  - Region enum (REG_ROM, REG_RAM, REG_IO, REG_NONE).
  - FSM state enum.
  - IO address constants 0xA000-0xA002.
  - Unmapped-read value 0xFF.
- One sub-module, z80_addr_decode: combinational region and IO-select decode from cpu_adr.
- FSM, cache and interrupt logic stay in the top.

Test Plan:
- ROM miss then hit: read 0x1234 with rom_ack after 5 cycles carrying 0x3E -> wait_n low 6 cycles, cpu_din = 0x3E, rom_adr = 0x1234. Re-read 0x1234 -> 0 wait cycles, data 0x3E, no rom_req.
- RAM write/read with mirror: write 0x5A to 0x8010, then read 0x8810 -> exactly one ram_we pulse at ram_adr = 0x010; read has 1 wait cycle and returns 0x5A.
- IO and unmapped: in_dsw = 0xC3, read 0xA002 -> 0xC3 with no wait. Read 0xC000 -> 0xFF. Write 0xA001 = 0x01 -> flip = 1.
- Interrupt: write 0xA000 = 0x01, pulse vblank -> cpu_intreq = 1 on the next edge. Write 0xA002 -> 0. vblank edge and 0xA002 write in the same cycle -> cpu_intreq stays 0.
- Timeout: ROM miss with no rom_ack -> after 255 cycles, wait_n releases, cpu_din = 0xFF, cache not updated (the next read of that address misses again).
- Reset mid-fetch: drop reset_n during ROM_FETCH -> rom_req = 0 and wait_n = 1 immediately. After release, FSM is IDLE and the cache is invalid (the next read misses).

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus target: address regions,
// FSM states and the fixed IO register addresses.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ROM_FETCH,
    RAM_RD,
    HOLD
  } state_t;

  localparam logic [15:0] ADR_P1  = 16'hA000;
  localparam logic [15:0] ADR_P2  = 16'hA001;
  localparam logic [15:0] ADR_DSW = 16'hA002;

  localparam logic [1:0] IO_P1  = 2'd0;
  localparam logic [1:0] IO_P2  = 2'd1;
  localparam logic [1:0] IO_DSW = 2'd2;

  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/z80_addr_decode.sv
// Combinational address-map decode: region plus which IO register is selected.
module z80_addr_decode
  import z80_bus_pkg::*;
(
  input  logic [15:0] cpu_adr,
  output region_t     region,
  output logic [1:0]  io_sel
);

  always_comb begin
    region = REG_NONE;
    io_sel = IO_P1;
    if (!cpu_adr[15]) begin
      region = REG_ROM;
    end else if (cpu_adr[15:12] == 4'h8) begin
      region = REG_RAM;
    end else if (cpu_adr == ADR_P1) begin
      region = REG_IO;
      io_sel = IO_P1;
    end else if (cpu_adr == ADR_P2) begin
      region = REG_IO;
      io_sel = IO_P2;
    end else if (cpu_adr == ADR_DSW) begin
      region = REG_IO;
      io_sel = IO_DSW;
    end
  end

endmodule

// File: rtl/z80_bus_target.sv
// Z80 bus responder: ROM (single-entry cache + external fetch), work RAM,
// input ports, control registers and the VBLANK interrupt.
module z80_bus_target
  import z80_bus_pkg::*;
#(
  parameter int ROM_AW      = 15,
  parameter int RAM_AW      = 11,
  parameter int ROM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       cpu_adr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              cpu_wait_n,
  output logic              cpu_intreq,
  input  logic              vblank,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_adr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_adr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic [7:0]        in_p1,
  input  logic [7:0]        in_p2,
  input  logic [7:0]        in_dsw,
  output logic              flip
);

  localparam int TW = $clog2(ROM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ROM_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ROM_TIMEOUT);

  state_t            state, state_nx;
  region_t           region;
  logic [1:0]        io_sel;
  logic [7:0]        io_rd;
  logic              start, cache_hit, miss_go, tmo_hit;
  logic              io_wr, irq_set, irq_clr;
  logic [7:0]        din_q;
  logic              cache_vld;
  logic [ROM_AW-1:0] cache_tag;
  logic [7:0]        cache_dat;
  logic [TW-1:0]     tmo_cnt;
  logic [RAM_AW-1:0] ram_adr_q;
  logic              irq_en, vb_q;

  z80_addr_decode u_dec (
    .cpu_adr (cpu_adr),
    .region  (region),
    .io_sel  (io_sel)
  );

  always_comb begin
    case (io_sel)
      IO_P1:   io_rd = in_p1;
      IO_P2:   io_rd = in_p2;
      default: io_rd = in_dsw;
    endcase
  end

  // Gating with reset_n keeps wait_n high and outputs at reset values while in reset.
  assign start     = reset_n && (state == IDLE) && (cpu_rd || cpu_wr);
  assign cache_hit = cache_vld && (cache_tag == cpu_adr[ROM_AW-1:0]);
  assign tmo_hit   = (state == ROM_FETCH) && !rom_ack && (tmo_cnt == TMO_LAST);
  assign ram_wdata = cpu_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cpu_wait_n = 1'b1;
    cpu_din    = din_q;
    ram_we     = 1'b0;
    ram_adr    = ram_adr_q;
    miss_go    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = HOLD;
          if (cpu_wr) begin
            if (region == REG_RAM) begin
              ram_we  = 1'b1;
              ram_adr = cpu_adr[RAM_AW-1:0];
            end
          end else begin
            case (region)
              REG_ROM: begin
                if (cache_hit) begin
                  cpu_din = cache_dat;
                end else begin
                  cpu_wait_n = 1'b0;
                  miss_go    = 1'b1;
                  state_nx   = ROM_FETCH;
                end
              end
              REG_RAM: begin
                cpu_wait_n = 1'b0;
                ram_adr    = cpu_adr[RAM_AW-1:0];
                state_nx   = RAM_RD;
              end
              REG_IO:  cpu_din = io_rd;
              default: cpu_din = UNMAPPED_RD;
            endcase
          end
        end
      end
      // Ignores the strobes so a late ack is always consumed by this fetch.
      ROM_FETCH: begin
        cpu_wait_n = 1'b0;
        if (rom_ack || tmo_hit) state_nx = HOLD;
      end
      RAM_RD: begin
        cpu_din  = ram_rdata;
        state_nx = HOLD;
      end
      HOLD: begin
        if (!cpu_rd && !cpu_wr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q     <= UNMAPPED_RD;
      rom_req   <= 1'b0;
      rom_adr   <= '0;
      tmo_cnt   <= '0;
      cache_vld <= 1'b0;
      cache_tag <= '0;
      cache_dat <= '0;
      ram_adr_q <= '0;
    end else begin
      if (start && !cpu_wr) din_q <= cpu_din;
      if (start && region == REG_RAM) ram_adr_q <= cpu_adr[RAM_AW-1:0];
      if (miss_go) begin
        rom_req <= 1'b1;
        rom_adr <= cpu_adr[ROM_AW-1:0];
        tmo_cnt <= '0;
      end
      if (state == ROM_FETCH) begin
        if (rom_ack) begin
          rom_req   <= 1'b0;
          din_q     <= rom_data;
          cache_vld <= 1'b1;
          cache_tag <= rom_adr;
          cache_dat <= rom_data;
        end else if (tmo_hit) begin
          rom_req <= 1'b0;
          din_q   <= UNMAPPED_RD;
        end else if (tmo_cnt != TMO_MAX) begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (state == RAM_RD) din_q <= ram_rdata;
    end
  end

  assign io_wr   = start && cpu_wr && (region == REG_IO);
  assign irq_clr = io_wr && ((io_sel == IO_DSW) || (io_sel == IO_P1 && !cpu_dout[0]));
  assign irq_set = vblank && !vb_q && irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en     <= 1'b0;
      flip       <= 1'b0;
      vb_q       <= 1'b0;
      cpu_intreq <= 1'b0;
    end else begin
      vb_q <= vblank;
      if (io_wr && io_sel == IO_P1) irq_en <= cpu_dout[0];
      if (io_wr && io_sel == IO_P2) flip   <= cpu_dout[0];
      if (irq_clr)      cpu_intreq <= 1'b0;
      else if (irq_set) cpu_intreq <= 1'b1;
    end
  end

endmodule
